lsu_dmem_master: RTL and testbench

- Load/store initiator that drives the byte-addressed data memory port: daddr, dwdata, we[3:0] out; drdata in.
- The memory returns a combinational read of the aligned word at daddr & ~3. It writes enabled byte lanes on posedge clk.
- Accepts one RV32I load/store request from the core, generates aligned word accesses and byte enables, and returns sign/zero-extended load data.
- Misaligned accesses that cross a word boundary are split into two memory beats.

---
 rtl/lsu_dmem_master.sv | 207 ++++++++++++++++++++
 tb/tb_lsu_dmem_master.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master
//   Load/store initiator between an RV32I core and a byte-addressed data
//   memory. It takes one request at a time and turns it into one or two
//   aligned word beats with per-byte write enables. Load data comes back
//   sign- or zero-extended.
//
//   The memory reads the aligned word at daddr combinationally. It writes
//   the enabled byte lanes on posedge clk.
//
// Parameters
//   SPLIT_EN   1: word-crossing accesses are split into two beats
//              0: word-crossing accesses respond with resp_err, no beat
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_store       1 = store, 0 = load
//   req_funct3      RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr        byte address
//   req_wdata       right-justified store data
//   resp_valid      one-cycle response pulse
//   resp_rdata      extended load data, 0 for stores and errors (held)
//   resp_err        illegal funct3 or unsupported misalignment (held)
//   daddr           word-aligned memory address
//   dwdata          lane-aligned write data
//   we              per-byte write enables
//   drdata          memory read data
module lsu_dmem_master #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state;
  logic        r_store;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] lo;
  logic [31:0] hi;

  // Access size in bytes, taken from funct3[1:0]. The unsigned variants
  // share the low two bits with their signed counterparts.
  function automatic logic [2:0] size_bytes(input logic [1:0] f3lo);
    case (f3lo)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [1:0] f3lo);
    crosses = ({1'b0, off} + size_bytes(f3lo)) > 3'd4;
  endfunction

  logic req_illegal;
  logic req_err;
  logic r_cross;

  assign req_illegal = req_store ? (req_funct3 >= 3'd3)
                                 : (req_funct3 == 3'd3 || req_funct3 == 3'd6 ||
                                    req_funct3 == 3'd7);
  assign req_err     = req_illegal | (crosses(req_addr[1:0], req_funct3[1:0]) & ~SPLIT_EN);
  assign r_cross     = crosses(r_addr[1:0], r_f3[1:0]);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Byte mask and lane-aligned data across a 64-bit window. The low half
  // belongs to the first beat and the high half to the second.
  logic [3:0]  size_mask;
  logic [31:0] wmask32;
  logic [7:0]  m8;
  logic [63:0] d64;

  always_comb begin
    size_mask = 4'b1111;
    case (r_f3[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign wmask32 = {{8{size_mask[3]}}, {8{size_mask[2]}},
                    {8{size_mask[1]}}, {8{size_mask[0]}}};
  assign m8      = {4'b0000, size_mask} << r_addr[1:0];
  assign d64     = {32'b0, r_wdata & wmask32} << {r_addr[1:0], 3'b000};

  // Memory-side drive is decoded purely from the registered state. IDLE
  // and RESP therefore present all zeros, so nothing is written outside
  // a beat. A reset also drops we immediately.
  always_comb begin
    daddr  = '0;
    we     = '0;
    dwdata = '0;
    case (state)
      ACC0: begin
        daddr  = {r_addr[31:2], 2'b00};
        we     = r_store ? m8[3:0] : 4'b0000;
        dwdata = d64[31:0];
      end
      ACC1: begin
        daddr  = {r_addr[31:2], 2'b00} + 32'd4;
        we     = r_store ? m8[7:4] : 4'b0000;
        dwdata = d64[63:32];
      end
      default: ;
    endcase
  end

  // Load result assembly works on {hi,lo} with the current beat forwarded
  // from drdata. This lets the response register fill on the same edge
  // that ends the last beat. For a non-crossing access the shifted window
  // never reaches the upper word, so its contents do not matter there.
  logic [63:0] word64;
  logic [31:0] raw;
  logic [31:0] load_ext;

  assign word64 = (state == ACC1) ? {drdata, lo} : {hi, drdata};
  assign raw    = 32'(word64 >> {r_addr[1:0], 3'b000});

  always_comb begin
    load_ext = raw;
    case (r_f3)
      3'd0:    load_ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    load_ext = {{16{raw[15]}}, raw[15:0]};
      3'd4:    load_ext = {24'b0, raw[7:0]};
      3'd5:    load_ext = {16'b0, raw[15:0]};
      default: load_ext = raw;
    endcase
  end

  // Request capture, beat sequencing and response registers. The response
  // fields only change on entry to RESP, so they hold until the next
  // response. A split store cut off by reset keeps its first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r_store    <= 1'b0;
      r_f3       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      lo         <= '0;
      hi         <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_store <= req_store;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              state <= ACC0;
            end
          end
        end
        ACC0: begin
          lo <= drdata;
          if (SPLIT_EN && r_cross) begin
            state <= ACC1;
          end else begin
            resp_err   <= 1'b0;
            resp_rdata <= r_store ? 32'd0 : load_ext;
            state      <= RESP;
          end
        end
        ACC1: begin
          hi         <= drdata;
          resp_err   <= 1'b0;
          resp_rdata <= r_store ? 32'd0 : load_ext;
          state      <= RESP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master
//   Bench for lsu_dmem_master. It contains a 1 KiB byte memory model,
//   addressed by daddr[9:0], and one instance each with SPLIT_EN=1 and
//   SPLIT_EN=0. It runs a table of directed vectors, hand sequences for
//   busy-hold and mid-access reset, and randomized requests checked
//   against a byte-level reference model.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid2;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, daddr, dwdata, drdata;
  logic [3:0]  we;

  logic        req_ready2, resp_valid2, resp_err2;
  logic [31:0] resp_rdata2, daddr2, dwdata2, drdata2;
  logic [3:0]  we2;

  always #5 clk = ~clk;

  lsu_dmem_master #(.SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  lsu_dmem_master #(.SPLIT_EN(1'b0)) u_nosplit (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .daddr(daddr2), .dwdata(dwdata2), .we(we2), .drdata(drdata2)
  );

  // Memory model. Only the split-enabled instance writes. Preloading goes
  // through the same process as a one-cycle bulk copy.
  logic [7:0] mem [0:1023];
  logic [7:0] init_image [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic       init_en = 1'b0;
  logic [9:0] base, base2;

  assign base    = {daddr[9:2], 2'b00};
  assign base2   = {daddr2[9:2], 2'b00};
  assign drdata  = {mem[base + 10'd3], mem[base + 10'd2], mem[base + 10'd1], mem[base]};
  assign drdata2 = {mem[base2 + 10'd3], mem[base2 + 10'd2], mem[base2 + 10'd1], mem[base2]};

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_image[i];
    end else begin
      for (int l = 0; l < 4; l++)
        if (we[l]) mem[base + 10'(l)] <= dwdata[8*l +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] beat_addr [0:7];
  logic [3:0]  beat_we   [0:7];
  logic [31:0] beat_data [0:7];

  typedef struct {
    string      name;
    bit         store;
    bit [2:0]   f3;
    bit [31:0]  addr;
    bit [31:0]  wdata;
    bit [31:0]  exp_rdata;
    bit         exp_err;
    int         exp_lat;
    bit [31:0]  a0;
    bit [3:0]   we0;
    bit [31:0]  d0;
    bit [31:0]  a1;
    bit [3:0]   we1;
    bit [31:0]  d1;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // One request on the chosen instance. Returns the response and the
  // number of cycles from accept to resp_valid, with 99 on timeout. The
  // per-cycle memory drive is recorded in the beat arrays.
  task automatic applyStimulus(input bit which, input bit store, input bit [2:0] f3,
                               input bit [31:0] addr, input bit [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat);
    bit got = 0;
    rdata = '0;
    err   = 1'b0;
    lat   = 99;
    for (int k = 0; k < 8; k++) begin
      beat_addr[k] = '0; beat_we[k] = '0; beat_data[k] = '0;
    end
    @(negedge clk);
    req_store  = store;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    if (which) req_valid2 = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
      end
      beat_addr[k] = which ? daddr2  : daddr;
      beat_we[k]   = which ? we2     : we;
      beat_data[k] = which ? dwdata2 : dwdata;
      if (which ? resp_valid2 : resp_valid) begin
        got   = 1;
        lat   = k;
        rdata = which ? resp_rdata2 : resp_rdata;
        err   = which ? resp_err2 : resp_err;
      end
    end
  endtask

  // Reference model: applies a request to ref_mem byte by byte and
  // predicts the response and its latency.
  function automatic void model_req(input bit store, input bit [2:0] f3,
                                    input bit [31:0] addr, input bit [31:0] wdata,
                                    output bit [31:0] r, output bit e, output int lat);
    int  size = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    int  off  = int'(addr % 4);
    bit  illegal = store ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
    bit [31:0] v = 0;
    r = 0; e = 0;
    if (illegal) begin
      e = 1; lat = 1;
      return;
    end
    lat = (off + size > 4) ? 3 : 2;
    for (int i = 0; i < size; i++) begin
      bit [31:0] a = addr + i;
      if (store) ref_mem[a % 1024] = 8'(wdata >> (8 * i));
      else       v = v | (32'(ref_mem[a % 1024]) << (8 * i));
    end
    if (!store) begin
      if (f3 == 0 && v >= 32'h80)   v = v | 32'hFFFFFF00;
      if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF0000;
      r = v;
    end
  endfunction

  function automatic void add_vec(string n, bit s, bit [2:0] f, bit [31:0] a, bit [31:0] w,
                                  bit [31:0] er, bit ee, int el,
                                  bit [31:0] a0, bit [3:0] w0, bit [31:0] d0,
                                  bit [31:0] a1, bit [3:0] w1, bit [31:0] d1);
    vec_t v;
    v.name = n; v.store = s; v.f3 = f; v.addr = a; v.wdata = w;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    v.a0 = a0; v.we0 = w0; v.d0 = d0; v.a1 = a1; v.we1 = w1; v.d1 = d1;
    vecs.push_back(v);
  endfunction

  task automatic load_image();
    @(negedge clk);
    init_en = 1'b1;
    @(negedge clk);
    init_en = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit [31:0]   exp_r;
    bit          exp_e;
    int          exp_l;
    int          seen;
    int          bad;

    rst = 1'b1;
    req_valid = 1'b0; req_valid2 = 1'b0;
    req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

    // Fill the table of directed vectors.
    add_vec("LW_10",   0, 2, 32'h10, 0, 32'h44332211, 0, 2, 32'h10, 4'h0, 0, 0, 0, 0);
    add_vec("LB_17",   0, 0, 32'h17, 0, 32'hFFFFFF88, 0, 2, 32'h14, 4'h0, 0, 0, 0, 0);
    add_vec("LBU_17",  0, 4, 32'h17, 0, 32'h00000088, 0, 2, 32'h14, 4'h0, 0, 0, 0, 0);
    add_vec("LH_16",   0, 1, 32'h16, 0, 32'hFFFF8877, 0, 2, 32'h14, 4'h0, 0, 0, 0, 0);
    add_vec("LH_13",   0, 1, 32'h13, 0, 32'h00005544, 0, 3, 32'h10, 4'h0, 0, 32'h14, 4'h0, 0);
    add_vec("LW_12",   0, 2, 32'h12, 0, 32'h66554433, 0, 3, 32'h10, 4'h0, 0, 32'h14, 4'h0, 0);
    add_vec("SW_15",   1, 2, 32'h15, 32'hDEADBEEF, 0, 0, 3,
            32'h14, 4'hE, 32'hADBEEF00, 32'h18, 4'h1, 32'h000000DE);
    add_vec("LW_15",   0, 2, 32'h15, 0, 32'hDEADBEEF, 0, 3, 32'h14, 4'h0, 0, 32'h18, 4'h0, 0);
    add_vec("SB_12",   1, 0, 32'h12, 32'h123456A5, 0, 0, 2, 32'h10, 4'h4, 32'h00A50000, 0, 0, 0);
    add_vec("LW_10b",  0, 2, 32'h10, 0, 32'h44A52211, 0, 2, 32'h10, 4'h0, 0, 0, 0, 0);
    add_vec("LH_17",   0, 1, 32'h17, 0, 32'hFFFFDEAD, 0, 3, 32'h14, 4'h0, 0, 32'h18, 4'h0, 0);
    add_vec("LHU_17",  0, 5, 32'h17, 0, 32'h0000DEAD, 0, 3, 32'h14, 4'h0, 0, 32'h18, 4'h0, 0);
    add_vec("SH_1A",   1, 1, 32'h1A, 32'hCAFE1234, 0, 0, 2, 32'h18, 4'hC, 32'h12340000, 0, 0, 0);
    add_vec("LW_18",   0, 2, 32'h18, 0, 32'h123400DE, 0, 2, 32'h18, 4'h0, 0, 0, 0, 0);
    add_vec("ST_F3",   1, 3, 32'h10, 32'hFFFFFFFF, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add_vec("ST_F5",   1, 5, 32'h13, 32'hFFFFFFFF, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add_vec("LD_F3",   0, 3, 32'h10, 0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add_vec("LD_F6",   0, 6, 32'h10, 0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add_vec("LD_F7",   0, 7, 32'h11, 0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0);
    add_vec("SH_wrap", 1, 1, 32'hFFFFFFFF, 32'h0000BBAA, 0, 0, 3,
            32'hFFFFFFFC, 4'h8, 32'hAA000000, 32'h0, 4'h1, 32'h000000BB);
    add_vec("LHU_wrap", 0, 5, 32'hFFFFFFFF, 0, 32'h0000BBAA, 0, 3,
            32'hFFFFFFFC, 4'h0, 0, 32'h0, 4'h0, 0);

    for (int i = 0; i < 1024; i++) init_image[i] = 8'h00;
    for (int i = 0; i < 8; i++) init_image[16 + i] = 8'(8'h11 * (i + 1));
    load_image();

    // Reset values while rst is still asserted.
    #2;
    checkOutput("rst_ready",   {31'b0, req_ready}, 32'd1);
    checkOutput("rst_valid",   {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_we",      {28'b0, we}, 32'd0);
    checkOutput("rst_daddr",   daddr, 32'd0);
    checkOutput("rst_dwdata",  dwdata, 32'd0);
    checkOutput("rst_rdata",   resp_rdata, 32'd0);
    checkOutput("rst_err",     {31'b0, resp_err}, 32'd0);
    checkOutput("rst_ready2",  {31'b0, req_ready2}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      checkOutput({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_err"},   {31'b0, er}, {31'b0, vecs[i].exp_err});
      checkOutput({vecs[i].name, "_lat"},   lat, vecs[i].exp_lat);
      checkOutput({vecs[i].name, "_a0"},    beat_addr[1], vecs[i].a0);
      checkOutput({vecs[i].name, "_we0"},   {28'b0, beat_we[1]}, {28'b0, vecs[i].we0});
      checkOutput({vecs[i].name, "_d0"},    beat_data[1], vecs[i].d0);
      if (vecs[i].exp_lat == 3) begin
        checkOutput({vecs[i].name, "_a1"},  beat_addr[2], vecs[i].a1);
        checkOutput({vecs[i].name, "_we1"}, {28'b0, beat_we[2]}, {28'b0, vecs[i].we1});
        checkOutput({vecs[i].name, "_d1"},  beat_data[2], vecs[i].d1);
      end
      if (lat <= 6)
        checkOutput({vecs[i].name, "_resp_we"}, {28'b0, beat_we[lat]}, 32'd0);
    end

    // Hold req_valid through a split LW 0x12 while changing the request.
    // The original request must complete, and nothing new is accepted
    // before IDLE.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h12; req_wdata = 0;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_addr   = 32'h10;
        req_funct3 = 3'd0;
      end
      checkOutput($sformatf("hold_ready_c%0d", k), {31'b0, req_ready}, 32'd0);
      checkOutput($sformatf("hold_valid_c%0d", k), {31'b0, resp_valid}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        checkOutput("hold_rdata", resp_rdata, 32'hEF5544A5);
        req_valid = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("hold_idle_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("hold_idle_valid", {31'b0, resp_valid}, 32'd0);

    // SPLIT_EN=0: a crossing access errors out without a beat, and a
    // non-crossing one still works.
    applyStimulus(1, 0, 3'd2, 32'h11, 0, rd, er, lat);
    checkOutput("ns_LW11_err",   {31'b0, er}, 32'd1);
    checkOutput("ns_LW11_lat",   lat, 32'd1);
    checkOutput("ns_LW11_rdata", rd, 32'd0);
    checkOutput("ns_LW11_we",    {28'b0, beat_we[1]}, 32'd0);
    checkOutput("ns_LW11_daddr", beat_addr[1], 32'd0);
    applyStimulus(1, 0, 3'd1, 32'h12, 0, rd, er, lat);
    checkOutput("ns_LH12_err",   {31'b0, er}, 32'd0);
    checkOutput("ns_LH12_lat",   lat, 32'd2);
    checkOutput("ns_LH12_rdata", rd, 32'h000044A5);
    checkOutput("ns_LH12_daddr", beat_addr[1], 32'h10);

    // Randomized requests against the reference model.
    for (int i = 0; i < 1024; i++) begin
      init_image[i] = 8'($urandom);
      ref_mem[i]    = init_image[i];
    end
    load_image();
    for (int n = 0; n < 300; n++) begin
      bit        s = 1'($urandom_range(0, 1));
      bit [2:0]  f = 3'($urandom_range(0, 7));
      bit [31:0] a = $urandom;
      bit [31:0] w = $urandom;
      model_req(s, f, a, w, exp_r, exp_e, exp_l);
      applyStimulus(0, s, f, a, w, rd, er, lat);
      checkOutput("rnd_rdata", rd, exp_r);
      checkOutput("rnd_err",   {31'b0, er}, {31'b0, exp_e});
      checkOutput("rnd_lat",   lat, exp_l);
      if (!s && lat <= 6)
        checkOutput("rnd_load_we", {28'b0, beat_we[1] | beat_we[2] | beat_we[lat]}, 32'd0);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    checkOutput("rnd_mem", bad, 32'd0);

    // Reset during the second beat of SW 0x15. The first beat stays
    // committed, the second is dropped, and no response appears.
    for (int i = 0; i < 1024; i++) init_image[i] = 8'h00;
    init_image[20] = 8'h55; init_image[21] = 8'h66;
    init_image[22] = 8'h77; init_image[23] = 8'h88; init_image[24] = 8'h00;
    load_image();
    applyStimulus(0, 0, 3'd2, 32'h14, 0, rd, er, lat);
    checkOutput("pre_rst_LW14", rd, 32'h88776655);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h15; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_acc1_we", {28'b0, we}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_we",     {28'b0, we}, 32'd0);
    checkOutput("mid_rst_daddr",  daddr, 32'd0);
    checkOutput("mid_rst_dwdata", dwdata, 32'd0);
    checkOutput("mid_rst_valid",  {31'b0, resp_valid}, 32'd0);
    checkOutput("mid_rst_rdata",  resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {31'b0, req_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checkOutput("post_rst_no_resp", seen, 32'd0);
    checkOutput("post_rst_mem14",
                {mem[10'h17], mem[10'h16], mem[10'h15], mem[10'h14]}, 32'hADBEEF55);
    checkOutput("post_rst_mem18", {24'b0, mem[10'h18]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
